alu_vec_aux: RTL and testbench

ALU_VEC_AUX -- requirements
Module: alu_vec_aux

---
 rtl/alu_vec_aux.sv | 98 +++++++++
 tb/tb_alu_vec_aux.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_vec_aux.sv
// One lane of a 16-bit vector ALU. Inputs are combined into a result and an {N,Z,C,V}
// flag nibble, and both are registered every cycle. In scalar mode only lane 0 computes.
module alu_vec_aux #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [2:0]          opcode,
    input  logic                flag_scalar,
    input  logic signed [31:0]  instance_num,
    output logic [DATA_W-1:0]   result,
    output logic [3:0]          flags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } op_e;

    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic [2*DATA_W-1:0] prod;
    logic [3:0]          shamt;
    logic                lane_active;
    logic [DATA_W-1:0]   result_d, result_q;
    logic [3:0]          flags_d, flags_q;
    logic [DATA_W-1:0]   res_c;
    logic                c_c, v_c;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    assign shamt    = b[3:0];

    // Negative lane numbers never match zero, so they are gated off in scalar mode too.
    assign lane_active = !flag_scalar || (instance_num == 32'sd0);

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        unique case (op_e'(opcode))
            OP_ADD: begin
                res_c = sum_ext[DATA_W-1:0];
                c_c   = sum_ext[DATA_W];
                v_c   = (a[DATA_W-1] == b[DATA_W-1]) && (res_c[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                res_c = diff_ext[DATA_W-1:0];
                c_c   = !diff_ext[DATA_W];
                v_c   = (a[DATA_W-1] != b[DATA_W-1]) && (res_c[DATA_W-1] != a[DATA_W-1]);
            end
            OP_MUL: begin
                res_c = prod[DATA_W-1:0];
                c_c   = |prod[2*DATA_W-1:DATA_W];
                v_c   = c_c;
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            OP_SLL: res_c = a << shamt;
            OP_SRL: res_c = a >> shamt;
            default: res_c = '0;
        endcase
    end

    always_comb begin
        result_d = '0;
        flags_d  = 4'b0000;
        if (lane_active) begin
            result_d = res_c;
            flags_d  = {res_c[DATA_W-1], (res_c == '0), c_c, v_c};
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_vec_aux.sv
// Scoreboard bench for alu_vec_aux: directed vectors push expected values, a monitor
// pops and compares one cycle later; reset behaviour is checked directly.
module tb_alu_vec_aux;

    logic               clk;
    logic               rst_n;
    logic [15:0]        a;
    logic [15:0]        b;
    logic [2:0]         opcode;
    logic               flag_scalar;
    logic signed [31:0] instance_num;
    logic [15:0]        result;
    logic [3:0]         flags;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_vec_aux dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .flag_scalar (flag_scalar),
        .instance_num(instance_num),
        .result      (result),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string name, input logic [15:0] er, input logic [3:0] ef);
        checks++;
        if (result !== er || flags !== ef) begin
            failures++;
            $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                     name, result, flags, er, ef);
        end
    endtask

    task automatic drive(input logic [15:0] ta, input logic [15:0] tb_, input logic [2:0] op,
                         input logic fs, input int inst,
                         input logic [15:0] er, input logic [3:0] ef, input string name);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb_; opcode = op; flag_scalar = fs; instance_num = inst;
        e.r = er; e.f = ef; e.name = name;
        q.push_back(e);
    endtask

    // Monitor: the DUT presents a new registered output after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now(e.name, e.r, e.f);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b1; a = 16'hBEEF; b = 16'h1357; opcode = 3'b010;
        flag_scalar = 1'b0; instance_num = 0;
        #1 rst_n = 1'b0;
        #1 check_now("reset_async", 16'h0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1 check_now("reset_held", 16'h0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'h1234; b = 16'h5678; opcode = 3'b000;
        e.r = 16'h68AC; e.f = 4'b0000; e.name = "first_after_reset";
        q.push_back(e);

        drive(16'h1234, 16'h5678, 3'b000, 0, 0, 16'h68AC, 4'b0000, "add_basic");
        drive(16'hFFFF, 16'h0001, 3'b000, 0, 0, 16'h0000, 4'b0110, "add_carry_zero");
        drive(16'h7FFF, 16'h0001, 3'b000, 0, 0, 16'h8000, 4'b1001, "add_overflow");
        drive(16'h5678, 16'h1234, 3'b001, 0, 0, 16'h4444, 4'b0010, "sub_basic");
        drive(16'h0000, 16'h0001, 3'b001, 0, 0, 16'hFFFF, 4'b1000, "sub_borrow");
        drive(16'h8000, 16'h0001, 3'b001, 0, 0, 16'h7FFF, 4'b0011, "sub_overflow");
        drive(16'h1234, 16'h5678, 3'b010, 0, 0, 16'h0060, 4'b0011, "mul_high");
        drive(16'h0003, 16'h0004, 3'b010, 0, 0, 16'h000C, 4'b0000, "mul_small");
        drive(16'hF0F0, 16'h0FF0, 3'b011, 0, 0, 16'h00F0, 4'b0000, "and");
        drive(16'hF0F0, 16'h0FF0, 3'b100, 0, 0, 16'hFFF0, 4'b1000, "or");
        drive(16'hF0F0, 16'h0FF0, 3'b101, 0, 0, 16'hFF00, 4'b1000, "xor");
        drive(16'h8001, 16'h0011, 3'b110, 0, 0, 16'h0002, 4'b0000, "sll");
        drive(16'h8001, 16'h0011, 3'b111, 0, 0, 16'h4000, 4'b0000, "srl");
        drive(16'h0001, 16'hFFF0, 3'b110, 0, 0, 16'h0001, 4'b0000, "sll_upper_ignored");
        drive(16'h8000, 16'h000F, 3'b111, 0, 0, 16'h0001, 4'b0000, "srl_max");
        drive(16'h1234, 16'h5678, 3'b000, 1, 0, 16'h68AC, 4'b0000, "scalar_inst0");
        drive(16'h1234, 16'h5678, 3'b000, 1, 3, 16'h0000, 4'b0000, "scalar_inst3");
        drive(16'h1234, 16'h5678, 3'b000, 1, -1, 16'h0000, 4'b0000, "scalar_inst_neg");
        drive(16'h1234, 16'h5678, 3'b000, 0, 3, 16'h68AC, 4'b0000, "vector_inst3");
        drive(16'h1234, 16'h1234, 3'b001, 1, 0, 16'h0000, 4'b0110, "scalar_sub_zero");
        drive(16'h8001, 16'h0011, 3'b111, 0, 7, 16'h4000, 4'b0000, "mode_switch_srl");

        // Drain the scoreboard before the mid-operation reset.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; opcode = 3'b000; flag_scalar = 1'b0; instance_num = 0;
        #2 rst_n = 1'b0;
        #1 check_now("reset_mid_cycle", 16'h0000, 4'b0000);
        @(posedge clk);
        #1 check_now("reset_discard", 16'h0000, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        e.r = 16'h68AC; e.f = 4'b0000; e.name = "resume_after_reset";
        q.push_back(e);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
